// File: rtl/spi_sensor_pkg.sv
// Framing constants and FSM state encoding shared by the sensor slave and
// the master side of the spi_sensor link.
package spi_sensor_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_LEAD_Z  = 4;
  localparam int DEF_TRAIL_Z = 4;
  localparam int DEF_FRAME_W = DEF_LEAD_Z + DEF_DATA_W + DEF_TRAIL_Z;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an idle-high asynchronous pin, followed by
// registered one-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '1;
      prev <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], din};
      prev <= sync[STAGES-1];
      rise <= sync[STAGES-1] & ~prev;
      fall <= ~sync[STAGES-1] & prev;
    end
  end

endmodule

// File: rtl/spi_sensor_slave.sv
// SPI slave (CPOL=1) that frames one held sample as {zeros, data, zeros}
// and shifts it out MSB first under control of an external master.
module spi_sensor_slave
  import spi_sensor_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LEAD_Z      = DEF_LEAD_Z,
  parameter int TRAIL_Z     = DEF_TRAIL_Z,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              ss,
  input  logic              sclk,
  output logic              miso,
  output logic              miso_oe,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              stale,
  output logic [1:0]        dbg_state
);

  localparam int FRAME_W = LEAD_Z + DATA_W + TRAIL_Z;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  // Handshake: a sample transfers on any clk edge where sample_valid and
  // sample_ready are both high; sample_valid may drop at any time.
  state_t              state;
  logic [DATA_W-1:0]   hold;
  logic                fresh;
  logic [FRAME_W-1:0]  shreg;
  logic [CNT_W-1:0]    cnt;
  logic [FRAME_W-1:0]  frame_word;
  logic                ss_rise, ss_fall, sclk_rise, sclk_fall_unused;

  assign frame_word = {{LEAD_Z{1'b0}}, hold, {TRAIL_Z{1'b0}}};
  assign dbg_state  = state;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ss),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold         <= '0;
      fresh        <= 1'b0;
      shreg        <= '0;
      cnt          <= '0;
      miso         <= 1'b0;
      miso_oe      <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_abort  <= 1'b0;
      stale        <= 1'b0;
      sample_ready <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      if (sample_valid && sample_ready) begin
        hold  <= sample_data;
        fresh <= 1'b1;
      end
      case (state)
        IDLE: begin
          miso         <= 1'b0;
          miso_oe      <= 1'b0;
          busy         <= 1'b0;
          sample_ready <= 1'b1;
          if (ss_fall) begin
            state        <= LOAD;
            busy         <= 1'b1;
            sample_ready <= 1'b0;
          end
        end
        LOAD: begin
          // Snapshot the hold register; the sample counts as consumed even
          // if the frame is later aborted.
          shreg        <= frame_word;
          stale        <= ~fresh;
          fresh        <= 1'b0;
          miso         <= frame_word[FRAME_W-1];
          miso_oe      <= 1'b1;
          cnt          <= CNT_W'(1);
          sample_ready <= 1'b1;
          state        <= SHIFT;
          if (ss_rise) begin
            state       <= IDLE;
            frame_abort <= 1'b1;
            cnt         <= '0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            busy        <= 1'b0;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state       <= IDLE;
            frame_abort <= 1'b1;
            cnt         <= '0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            busy        <= 1'b0;
          end else if (sclk_rise) begin
            // The rising edge after the last bit is the master returning
            // sclk to idle, so it ends the frame rather than shifting.
            if (cnt == CNT_W'(FRAME_W)) begin
              state <= DONE;
              miso  <= 1'b0;
            end else begin
              shreg <= shreg << 1;
              miso  <= shreg[FRAME_W-2];
              cnt   <= cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          miso <= 1'b0;
          if (ss_rise) begin
            state      <= IDLE;
            frame_done <= 1'b1;
            cnt        <= '0;
            miso_oe    <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sensor_slave.sv
// Bench for spi_sensor_slave: drives a CPOL=1 master at clk/10 and scores
// each completed or aborted frame against a queue of expected frames.
module tb_spi_sensor_slave;
  import spi_sensor_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sample_data = 8'h00;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic       ss = 1'b1;
  logic       sclk = 1'b1;
  logic       miso, miso_oe, busy, frame_done, frame_abort, stale;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  // Entry: {abort, stale, bits seen on miso at sclk falling edges}
  logic [17:0] exp_q[$];

  spi_sensor_slave dut (
    .clk          (clk),
    .rst          (rst),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .ss           (ss),
    .sclk         (sclk),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_abort  (frame_abort),
    .stale        (stale),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic push_sample(input logic [7:0] d);
    int waited;
    waited = 0;
    sample_data  = d;
    sample_valid = 1'b1;
    @(negedge clk);
    while (!sample_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("sample_accept", 32'(sample_ready), 32'd1);
    tick(1);
    sample_valid = 1'b0;
  endtask

  task automatic sclk_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      tick(5);
      sclk = 1'b1;
      tick(5);
    end
  endtask

  task automatic end_frame();
    tick(6);
    ss = 1'b1;
    tick(8);
  endtask

  task automatic run_frame(input int n);
    ss = 1'b0;
    tick(6);
    sclk_cycles(n);
    end_frame();
  endtask

  // monitor / scoreboard
  initial begin
    logic [15:0] cap;
    logic        sclk_q, ss_q;
    logic [17:0] exp;
    cap = '0;
    sclk_q = 1'b1;
    ss_q = 1'b1;
    forever begin
      @(negedge clk);
      if (ss_q && !ss) cap = '0;
      if (sclk_q && !sclk && !ss) begin
        cap = {cap[14:0], miso};
        check("miso_oe_in_frame", 32'(miso_oe), 32'd1);
      end
      sclk_q = sclk;
      ss_q = ss;
      if (frame_done || frame_abort) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse got done=%0b abort=%0b expected none", frame_done, frame_abort);
        end else begin
          exp = exp_q.pop_front();
          check("frame", 32'({frame_abort, stale, cap}), 32'(exp));
          check("miso_oe_after_frame", 32'(miso_oe), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic bad;
    tick(1);
    @(negedge clk);
    check("reset_outputs", 32'({miso, miso_oe, busy, frame_done, frame_abort, stale, sample_ready}), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    tick(1);
    rst = 1'b0;
    tick(1);
    @(negedge clk);
    check("ready_after_reset", 32'(sample_ready), 32'd1);

    // basic frame, then resend without new sample, then new sample
    push_sample(8'hA5);
    exp_q.push_back({1'b0, 1'b0, 16'h0A50});
    run_frame(16);
    exp_q.push_back({1'b0, 1'b1, 16'h0A50});
    run_frame(16);
    push_sample(8'h3C);
    exp_q.push_back({1'b0, 1'b0, 16'h03C0});
    run_frame(16);

    // abort after 7 sclk cycles; next frame restarts at bit 15
    exp_q.push_back({1'b1, 1'b1, 16'h0001});
    run_frame(7);
    exp_q.push_back({1'b0, 1'b1, 16'h03C0});
    run_frame(16);

    // sample accepted in the ss_fall cycle; another offered during LOAD
    exp_q.push_back({1'b0, 1'b0, 16'h0110});
    ss = 1'b0;
    tick(3);
    sample_data  = 8'h11;
    sample_valid = 1'b1;
    @(negedge clk);
    check("ready_at_ss_fall", 32'(sample_ready), 32'd1);
    tick(1);
    sample_data = 8'h77;
    @(negedge clk);
    check("load_state", 32'(dbg_state), 32'(LOAD));
    check("ready_in_load", 32'(sample_ready), 32'd0);
    check("busy_in_load", 32'(busy), 32'd1);
    tick(1);
    @(negedge clk);
    check("ready_after_load", 32'(sample_ready), 32'd1);
    tick(1);
    sample_valid = 1'b0;
    sclk_cycles(16);
    end_frame();
    exp_q.push_back({1'b0, 1'b0, 16'h0770});
    run_frame(16);

    // reset at bit 9 (six bits already taken by the master)
    ss = 1'b0;
    tick(6);
    sclk_cycles(6);
    tick(3);
    rst = 1'b1;
    ss  = 1'b1;
    tick(1);
    @(negedge clk);
    check("midframe_reset_outputs", 32'({miso, miso_oe, busy, frame_done, frame_abort, stale, sample_ready}), 32'd0);
    check("midframe_reset_state", 32'(dbg_state), 32'(IDLE));
    tick(1);
    rst = 1'b0;
    tick(2);
    push_sample(8'h5A);
    exp_q.push_back({1'b0, 1'b0, 16'h05A0});
    run_frame(16);

    // sclk activity while deselected is ignored
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sclk = 1'b0;
      for (int j = 0; j < 5; j++) begin
        @(negedge clk);
        if (miso_oe || busy) bad = 1'b1;
        tick(1);
      end
      sclk = 1'b1;
      for (int j = 0; j < 5; j++) begin
        @(negedge clk);
        if (miso_oe || busy) bad = 1'b1;
        tick(1);
      end
    end
    check("idle_while_deselected", 32'(bad), 32'd0);
    exp_q.push_back({1'b0, 1'b1, 16'h05A0});
    run_frame(16);

    tick(10);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
